// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around a single fulladder cell
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [1:0]     IDLE = 2'd0;
  localparam logic [1:0]     RUN  = 2'd1;
  localparam logic [1:0]     DONE = 2'd2;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;
  fulladder u_fa (
    .A   (r_a[0]),
    .B   (r_b[0]),
    .Cin (r_c),
    .S   (w_s),
    .Cout(w_co)
  );
  assign w_run  = r_state == RUN;
  assign w_last = r_cnt == LAST;
  // The newest sum bit enters at the MSB; older bits sit below it, LSB first in.
  generate
    if (WIDTH == 1) begin : g_one
      assign w_sum_nxt = w_s;
    end else begin : g_psum
      logic [WIDTH-2:0] r_psum;
      assign w_sum_nxt = {w_s, r_psum};
      // Partial sum shifts right once per RUN cycle
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_psum <= '0;
        else if (w_run) r_psum <= w_sum_nxt[WIDTH-1:1];
    end
  endgenerate
  // Control sequence IDLE -> RUN -> DONE -> IDLE with operand capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_a     <= a;
        r_b     <= b;
        r_c     <= cin;
        r_cnt   <= '0;
        r_state <= RUN;
      end
    end else if (w_run) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_c     <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      r_state <= w_last ? DONE : RUN;
    end else begin
      r_state <= IDLE;
    end
  // Result registers change only on the final RUN edge so partials never show
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_run && w_last) begin
      r_sum  <= w_sum_nxt;
      r_cout <= w_co;
    end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule
